// File: rtl/io_pkg.sv
// Shared register map for the memory-mapped input port: offsets, STATUS bit
// positions, W1C bit positions and the per-button status record.
package io_pkg;

    localparam logic [2:0] STATUS_OFF = 3'h0;
    localparam logic [2:0] SWITCH_OFF = 3'h4;

    localparam int ST_LSTICKY  = 0;
    localparam int ST_RSTICKY  = 1;
    localparam int ST_LLEVEL   = 2;
    localparam int ST_RLEVEL   = 3;
    localparam int ST_LCNT_LSB = 8;
    localparam int ST_RCNT_LSB = 16;

    localparam int W1C_LSTICKY = 0;
    localparam int W1C_RSTICKY = 1;
    localparam int W1C_COUNTS  = 8;

    localparam int NUM_BTNS = 2;

    typedef struct packed {
        logic       sticky;
        logic       level;
        logic [7:0] presses;
    } btn_status_t;

    function automatic logic [31:0] pack_status(input btn_status_t l, input btn_status_t r);
        logic [31:0] s;
        s                        = '0;
        s[ST_LSTICKY]            = l.sticky;
        s[ST_RSTICKY]            = r.sticky;
        s[ST_LLEVEL]             = l.level;
        s[ST_RLEVEL]             = r.level;
        s[ST_LCNT_LSB +: 8]      = l.presses;
        s[ST_RCNT_LSB +: 8]      = r.presses;
        return s;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level only takes
// a new value once the synced input has differed from it for CYCLES cycles.
module io_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] synced;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= '0;
            synced <= '0;
            level  <= '0;
            count  <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            // A vector that keeps changing while it differs keeps counting;
            // whatever it holds at the final cycle is captured whole.
            if (synced == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= synced;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped button/switch responder on the CPU data bus: debounced levels,
// sticky press flags with W1C clear, wrapping press counters, combinational reads.
module io_input_port
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0080,
    parameter int          DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEN,
    input  logic [31:0] dataAdr,
    input  logic [31:0] writeData,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [15:0] switch,
    output logic        hit,
    output logic [31:0] readData
);

    logic [NUM_BTNS-1:0]      btn_level;
    logic [NUM_BTNS-1:0]      btn_prev;
    logic [NUM_BTNS-1:0]      rise;
    logic [NUM_BTNS-1:0]      sticky;
    logic [NUM_BTNS-1:0]      clr_sticky;
    logic [NUM_BTNS-1:0][7:0] presses;
    logic [15:0]              sw_level;
    logic [2:0]               offset;
    logic                     status_wr;
    logic                     clr_counts;
    btn_status_t              l_stat;
    btn_status_t              r_stat;
    logic                     unused_bits;

    io_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clk   (clk),
        .reset (reset),
        .raw   (btnL),
        .level (btn_level[0])
    );

    io_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk   (clk),
        .reset (reset),
        .raw   (btnR),
        .level (btn_level[1])
    );

    io_debounce #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
        .clk   (clk),
        .reset (reset),
        .raw   (switch),
        .level (sw_level)
    );

    // Byte lanes within a word are irrelevant; only word offset 0 or 4 matters.
    assign offset     = {dataAdr[2], 2'b00};
    assign hit        = (dataAdr[31:3] == BASE_ADDR[31:3]);
    assign status_wr  = writeEN && hit && (offset == STATUS_OFF);
    assign clr_counts = status_wr && writeData[W1C_COUNTS];
    assign clr_sticky = status_wr ? {writeData[W1C_RSTICKY], writeData[W1C_LSTICKY]}
                                  : '0;
    assign rise       = btn_level & ~btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= '0;
            sticky   <= '0;
            presses  <= '0;
        end else begin
            btn_prev <= btn_level;
            // A press landing on a clear wins for the flag; a counter clear
            // wins over a simultaneous increment.
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (rise[i]) begin
                    sticky[i] <= 1'b1;
                end else if (clr_sticky[i]) begin
                    sticky[i] <= 1'b0;
                end
                if (clr_counts) begin
                    presses[i] <= '0;
                end else if (rise[i]) begin
                    presses[i] <= presses[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        l_stat = '{sticky: sticky[0], level: btn_level[0], presses: presses[0]};
        r_stat = '{sticky: sticky[1], level: btn_level[1], presses: presses[1]};
    end

    always_comb begin
        readData = '0;
        if (hit) begin
            if (offset == SWITCH_OFF) begin
                readData = {16'h0000, sw_level};
            end else begin
                readData = pack_status(l_stat, r_stat);
            end
        end
    end

    assign unused_bits = ^{dataAdr[1:0], writeData[31:9], writeData[7:2]};

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed register-map sequence plus randomized
// traffic, with read expectations queued and checked by a separate monitor.
module tb_io_input_port;

    localparam logic [31:0] BASE = 32'h0000_0080;
    localparam int          DC   = 4;

    logic        clk;
    logic        reset;
    logic        writeEN;
    logic [31:0] dataAdr;
    logic [31:0] writeData;
    logic        btnL;
    logic        btnR;
    logic [15:0] sw;
    logic        hit;
    logic [31:0] readData;

    io_input_port #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .writeEN   (writeEN),
        .dataAdr   (dataAdr),
        .writeData (writeData),
        .btnL      (btnL),
        .btnR      (btnR),
        .switch    (sw),
        .hit       (hit),
        .readData  (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        h;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;
    logic rd_vld = 1'b0;

    // ---------------- reference model ----------------
    // Group 0 = left button, 1 = right button, 2 = switch vector.
    logic [15:0] s1[3];
    logic [15:0] s2[3];
    logic [15:0] mlvl[3];
    logic [15:0] hist[3][DC];
    int          nh[3];
    bit          mprev[2];
    bit          mstk[2];
    int          mcnt[2];

    function automatic bit m_hit(input logic [31:0] a);
        return (a >> 3) == (BASE >> 3);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        if ((a & 32'h4) != 0) return {16'h0, mlvl[2]};
        return 32'(mstk[0]) + 32'(mstk[1]) * 2 + 32'(mlvl[0][0]) * 4 + 32'(mlvl[1][0]) * 8
             + 32'(mcnt[0]) * 256 + 32'(mcnt[1]) * 65536;
    endfunction

    // Accept a new level once the last DC synced samples since the previous
    // acceptance all differ from the current level.
    task automatic deb_step(input int g, input logic [15:0] v);
        bit all_diff;
        for (int k = DC - 1; k > 0; k--) hist[g][k] = hist[g][k-1];
        hist[g][0] = v;
        if (nh[g] < DC) nh[g]++;
        all_diff = (nh[g] == DC);
        for (int k = 0; k < DC; k++) if (hist[g][k] == mlvl[g]) all_diff = 0;
        if (all_diff) begin
            mlvl[g] = v;
            nh[g]   = 0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < 3; g++) begin
                s1[g] = 0; s2[g] = 0; mlvl[g] = 0; nh[g] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                mprev[i] = 0; mstk[i] = 0; mcnt[i] = 0;
            end
        end else begin
            bit wr_st;
            wr_st = writeEN && m_hit(dataAdr) && ((dataAdr & 32'h4) == 0);
            for (int i = 0; i < 2; i++) begin
                bit rise;
                rise = mlvl[i][0] && !mprev[i];
                if (rise) mstk[i] = 1;
                else if (wr_st && writeData[i]) mstk[i] = 0;
                if (wr_st && writeData[8]) mcnt[i] = 0;
                else if (rise) mcnt[i] = (mcnt[i] + 1) % 256;
                mprev[i] = mlvl[i][0];
            end
            for (int g = 0; g < 3; g++) deb_step(g, s2[g]);
            for (int g = 0; g < 3; g++) s2[g] = s1[g];
            s1[0] = {15'h0, btnL};
            s1[1] = {15'h0, btnR};
            s1[2] = sw;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_vld) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL read_no_expect adr=%h got hit=%b data=%h", dataAdr, hit, readData);
                end else begin
                    e = sb.pop_front();
                    if (readData !== e.d || hit !== e.h) begin
                        bad++;
                        $display("FAIL read tag=%0d adr=%h got hit=%b data=%h want hit=%b data=%h",
                                 e.tag, dataAdr, hit, readData, e.h, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        writeEN = 1'b0;
        rd_vld  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        rd_vld    = 1'b0;
        writeEN   = 1'b1;
        dataAdr   = a;
        writeData = d;
        @(negedge clk);
        writeEN   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic h);
        exp_t e;
        writeEN = 1'b0;
        dataAdr = a;
        e.d = d; e.h = h; e.tag = tag_n++;
        sb.push_back(e);
        rd_vld = 1'b1;
        @(negedge clk);
        rd_vld = 1'b0;
    endtask

    task automatic rd_model(input logic [31:0] a);
        rd(a, m_read(a), m_hit(a));
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1; writeEN = 1'b0; dataAdr = 32'h0; writeData = 32'h0;
        btnL = 1'b0; btnR = 1'b0; sw = 16'hFFFF;
        @(negedge clk);
        reset = 1'b0;

        // reset state, then switch level appears 6 cycles after release
        rd(32'h80, 32'h0, 1'b1);
        for (int k = 1; k <= 6; k++) rd(32'h84, (k == 6) ? 32'hFFFF : 32'h0, 1'b1);

        // 3-cycle glitch never reaches the level
        btnL = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) btnL = 1'b0;
            rd(32'h80, 32'h0, 1'b1);
        end

        // first press: level at +6, flag/count on the following cycle
        btnL = 1'b1;
        for (int k = 0; k < 8; k++)
            rd(32'h80, (k < 6) ? 32'h0 : (k == 6) ? 32'h4 : 32'h105, 1'b1);
        btnL = 1'b0;
        for (int k = 0; k < 8; k++) rd(32'h80, (k < 6) ? 32'h105 : 32'h101, 1'b1);
        btnL = 1'b1;
        for (int k = 0; k < 8; k++)
            rd(32'h80, (k < 6) ? 32'h101 : (k == 6) ? 32'h105 : 32'h205, 1'b1);
        btnL = 1'b0;
        idle(8);
        rd(32'h80, 32'h201, 1'b1);

        // W1C of the left flag leaves the count alone
        wr(32'h80, 32'h1);
        rd(32'h80, 32'h200, 1'b1);

        // clear landing on the same edge as a new press: set wins
        btnL = 1'b1;
        idle(6);
        wr(32'h80, 32'h1);
        rd(32'h80, 32'h305, 1'b1);
        btnL = 1'b0;
        idle(8);
        rd(32'h80, 32'h301, 1'b1);

        // 256 right presses wrap the counter
        for (int i = 0; i < 256; i++) begin
            btnR = 1'b1;
            idle(7);
            btnR = 1'b0;
            idle(7);
            if (i == 254) rd(32'h80, 32'h00FF_0303, 1'b1);
        end
        rd(32'h80, 32'h0000_0303, 1'b1);
        wr(32'h80, 32'h100);
        rd(32'h80, 32'h3, 1'b1);
        wr(32'h84, 32'h103);
        wr(32'h88, 32'h103);
        rd(32'h80, 32'h3, 1'b1);
        wr(32'h80, 32'h3);
        rd(32'h80, 32'h0, 1'b1);

        // address window edges
        rd(32'h88, 32'h0, 1'b0);
        rd(32'h7C, 32'h0, 1'b0);
        rd(32'h86, 32'hFFFF, 1'b1);
        rd(32'h83, 32'h0, 1'b1);

        // reset in the middle of a debounce
        btnL = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rd(32'h80, 32'h0, 1'b1);
        rd(32'h84, 32'h0, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) btnL = ~btnL;
            if ($urandom_range(0, 7) == 0) btnR = ~btnR;
            if ($urandom_range(0, 31) == 0) sw = 16'($urandom);
            r = $urandom_range(0, 15);
            case ($urandom_range(0, 5))
                0: a = 32'h80;
                1: a = 32'h84;
                2: a = 32'h80 + 32'($urandom_range(0, 7));
                3: a = 32'h88;
                4: a = 32'h7C;
                default: a = $urandom;
            endcase
            if (r < 2)      wr(32'h80, (r == 0) ? $urandom : 32'($urandom_range(0, 3)));
            else if (r < 4) wr(a, $urandom);
            else            rd_model(a);
        end

        idle(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input responder on the single-cycle MIPS data bus, sitting beside the display/data-memory decoder.
- Synchronises and debounces the two side buttons and the 16 slide switches.
- Records press events in sticky flags and wrapping press counters.
- Answers CPU loads combinationally and accepts CPU stores that clear the event flags (write-1-to-clear, W1C).

Parameters:
- BASE_ADDR, 32'h0000_0080, word-aligned base of the 2-word register window.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- reset  input  1  synchronous, active-high reset
- writeEN  input  1  CPU store strobe, same cycle as dataAdr/writeData
- dataAdr  input  32  CPU byte address (ALU result)
- writeData  input  32  CPU store data
- btnL  input  1  raw left button, asynchronous
- btnR  input  1  raw right button, asynchronous
- switch  input  16  raw slide switches, asynchronous
- hit  output  1  dataAdr falls in this block's window; parent uses it to select readData
- readData  output  32  register read data, combinational

Behaviour:
- Address decode:
  - hit = (dataAdr[31:3] == BASE_ADDR[31:3]); dataAdr[1:0] is ignored.
  - Offset 0x0 is STATUS; offset 0x4 is SWITCHES.
- Input synchroniser: each raw input passes through a 2-flop synchroniser; reset clears both stages to 0.
- Debounce, per input group (btnL 1 bit, btnR 1 bit, switch 16 bits as one vector):
  - The group holds a counter and a debounced level.
  - If synced == level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level <= synced, counter <= 0.
  - Else: counter <= counter + 1.
  - Result: level changes exactly DEBOUNCE_CYCLES cycles after the synced value first differs and stays different. A glitch shorter than that never reaches the level.
  - Pin-to-level latency: 2 + DEBOUNCE_CYCLES cycles.
  - Switch vector: any bit change during the wait restarts nothing. The count continues while the vector differs from the level, and the whole vector is captured at acceptance.
- Event detection: a debounced button 0->1 transition in cycle t sets that button's sticky flag and increments its 8-bit press counter (wraps 255->0) at the edge ending cycle t+1.
- STATUS read:
  - [0] left sticky, [1] right sticky, [2] left level, [3] right level.
  - [15:8] left press count, [23:16] right press count, other bits 0.
- SWITCHES read: {16'b0, debounced switch level}.
- Reads with hit=0: readData = 0.
- STATUS store (writeEN & hit & offset 0x0):
  - writeData[0]=1 clears the left sticky flag; writeData[1]=1 clears the right sticky flag.
  - writeData[8]=1 zeroes both press counters.
  - All other bits are ignored.
- SWITCHES store: ignored.
- Simultaneous set and clear in the same cycle: set wins, and the counter still increments unless writeData[8] is also set. In that case the counter becomes 0; clear wins for counters.
- Reset, including mid-debounce: all levels, counters, flags and press counts go to 0. readData follows immediately, so STATUS=0 and SWITCHES=0 after reset.

Decomposition:
- Shared package io_pkg:
  - offsets STATUS_OFF=3'h0, SWITCH_OFF=3'h4
  - status bit positions (ST_LSTICKY, ST_RSTICKY, ST_LLEVEL, ST_RLEVEL, ST_LCNT_LSB, ST_RCNT_LSB)
  - W1C bit positions
- Sub-module io_debounce:
  - parameters WIDTH and CYCLES; contains the synchroniser, counter and level register.
  - instantiated three times (WIDTH=1, 1, 16).

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR=0x80):
- Reset held 1 cycle with switch=16'hFFFF already applied -> STATUS=0 and SWITCHES=0 immediately after reset; SWITCHES=0x0000FFFF exactly 6 cycles after reset release.
- btnL high for 3 cycles then low -> level never rises; STATUS stays 0.
- btnL high held -> bit2 rises 6 cycles after the pin; the next cycle reads STATUS=0x0000_0105. Release, then repeat once -> STATUS=0x0000_0201 after the second release settles.
- Store 0x1 to 0x80 with the left flag set -> the next read shows bit0=0 and the count unchanged. A store of 0x1 landing in the same cycle as a new btnL rising edge -> bit0 stays 1 and the count increments.
- 256 debounced btnR presses -> right count wraps to 0 while bit1=1. A store of 0x100 -> both counts read 0.
- dataAdr=0x88 and dataAdr=0x7C -> hit=0, readData=0. dataAdr=0x86 -> hit=1, returns SWITCHES.
